game_over_glyph_fetch: RTL and testbench

//  Upstream glyph source for the GAME OVER overlay renderer. Takes the renderer's char_yx/char_line lookup address and

---
 rtl/game_over_glyph_fetch_pkg.sv | 51 +++++
 rtl/game_over_glyph_fetch_font_rom.sv | 27 ++
 rtl/game_over_glyph_fetch.sv | 152 +++++++++++++++
 tb/tb_game_over_glyph_fetch.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/game_over_glyph_fetch_pkg.sv
// Shared definitions for the GAME OVER glyph source: character codes, FSM states,
// the fixed text map and the 8x horizontal pixel expansion.
package game_over_glyph_fetch_pkg;

    localparam int unsigned GAME_OVER_TEXT_LEN = 9;
    localparam int unsigned CODE_W             = 4;
    localparam int unsigned FONT_ROW_W         = 3;
    localparam int unsigned FONT_W             = 8;
    localparam int unsigned PIX_W              = 64;

    typedef enum logic [CODE_W-1:0] {
        CH_BLANK = 4'd0,
        CH_G     = 4'd1,
        CH_A     = 4'd2,
        CH_M     = 4'd3,
        CH_E     = 4'd4,
        CH_O     = 4'd5,
        CH_V     = 4'd6,
        CH_R     = 4'd7
    } char_code_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REVEAL = 2'd1,
        ST_HOLD   = 2'd2
    } state_e;

    // Column -> character for "GAME OVER"; column 4 is the space.
    function automatic char_code_e text_char(input logic [CODE_W-1:0] col);
        char_code_e c;
        case (col)
            4'd0:    c = CH_G;
            4'd1:    c = CH_A;
            4'd2:    c = CH_M;
            4'd3:    c = CH_E;
            4'd5:    c = CH_O;
            4'd6:    c = CH_V;
            4'd7:    c = CH_E;
            4'd8:    c = CH_R;
            default: c = CH_BLANK;
        endcase
        return c;
    endfunction

    // Each font bit becomes 8 output pixels; font bit 7 lands in pixel bits [63:56].
    function automatic logic [PIX_W-1:0] expand_row(input logic [FONT_W-1:0] font);
        return {{8{font[7]}}, {8{font[6]}}, {8{font[5]}}, {8{font[4]}},
                {8{font[3]}}, {8{font[2]}}, {8{font[1]}}, {8{font[0]}}};
    endfunction

endpackage

// File: rtl/game_over_glyph_fetch_font_rom.sv
// 8x8 font for the letters of "GAME OVER"; pure combinational lookup, row 0 = top.
module font_rom_8x8
    import game_over_glyph_fetch_pkg::*;
(
    input  logic [3:0] code,
    input  logic [2:0] row,
    output logic [7:0] row_bits_c
);

    logic [0:7][7:0] glyph;

    always_comb begin
        glyph = 64'h0;
        case (code)
            CH_G:    glyph = 64'h3C66_C0C0_CE66_3E00;
            CH_A:    glyph = 64'h183C_6666_7E66_6600;
            CH_M:    glyph = 64'hC6EE_FED6_C6C6_C600;
            CH_E:    glyph = 64'hFEC0_C0FC_C0C0_FE00;
            CH_O:    glyph = 64'h7CC6_C6C6_C6C6_7C00;
            CH_V:    glyph = 64'hC6C6_C6C6_6C38_1000;
            CH_R:    glyph = 64'hFCC6_C6FC_D8CC_C600;
            default: glyph = 64'h0;
        endcase
        row_bits_c = glyph[row];
    end

endmodule

// File: rtl/game_over_glyph_fetch.sv
// GAME OVER glyph source: letter-by-letter reveal paced by vsync, optional blink in HOLD,
// and a 2-stage text-map / font pipeline feeding 64-pixel upscaled glyph rows.
module game_over_glyph_fetch
    import game_over_glyph_fetch_pkg::*;
#(
    parameter int unsigned REVEAL_FRAMES = 8,
    parameter int unsigned BLINK_FRAMES  = 30,
    parameter int unsigned TEXT_LEN      = GAME_OVER_TEXT_LEN
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        game_over,
    input  logic        vsync_in,
    input  logic [7:0]  char_yx_game_over,
    input  logic [7:0]  char_line_game_over,
    output logic [63:0] char_pixels_game_over,
    output logic        reveal_done
);

    localparam logic [7:0] REVEAL_LAST  = 8'(REVEAL_FRAMES - 1);
    localparam logic [7:0] BLINK_LAST   = 8'(BLINK_FRAMES - 1);
    localparam logic [3:0] TEXT_LEN_4   = 4'(TEXT_LEN);
    localparam logic       BLINK_ENABLE = (BLINK_FRAMES != 0);

    state_e      state_q, state_d;
    logic [3:0]  shown_q, shown_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic [7:0]  blink_cnt_q, blink_cnt_d;
    logic        blink_off_q, blink_off_d;
    logic        reveal_done_q, reveal_done_d;
    logic        vs_q;
    logic [3:0]  code_q, code_d;
    logic [63:0] pix_q, pix_d;

    logic        tick;
    logic [3:0]  cell_row;
    logic [3:0]  cell_col;
    logic        visible;
    logic [7:0]  font_bits_c;
    logic [1:0]  unused_line_bits;

    assign tick             = vsync_in & ~vs_q;
    assign cell_row         = char_yx_game_over[7:4];
    assign cell_col         = char_yx_game_over[3:0];
    assign unused_line_bits = char_line_game_over[7:6];

    // Reveal/blink FSM; dropping game_over overrides everything, including a tick.
    always_comb begin
        state_d     = state_q;
        shown_d     = shown_q;
        frame_cnt_d = frame_cnt_q;
        blink_cnt_d = blink_cnt_q;
        blink_off_d = blink_off_q;

        if (!game_over) begin
            state_d     = ST_IDLE;
            shown_d     = 4'd0;
            frame_cnt_d = 8'd0;
            blink_cnt_d = 8'd0;
            blink_off_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d     = ST_REVEAL;
                    shown_d     = 4'd1;
                    frame_cnt_d = 8'd0;
                    blink_cnt_d = 8'd0;
                    blink_off_d = 1'b0;
                end
                ST_REVEAL: begin
                    if (shown_q >= TEXT_LEN_4) begin
                        state_d = ST_HOLD;
                    end else if (tick) begin
                        if (frame_cnt_q == REVEAL_LAST) begin
                            frame_cnt_d = 8'd0;
                            shown_d     = shown_q + 4'd1;
                            if ((shown_q + 4'd1) >= TEXT_LEN_4) begin
                                state_d = ST_HOLD;
                            end
                        end else begin
                            frame_cnt_d = frame_cnt_q + 8'd1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (BLINK_ENABLE && tick) begin
                        if (blink_cnt_q == BLINK_LAST) begin
                            blink_cnt_d = 8'd0;
                            blink_off_d = ~blink_off_q;
                        end else begin
                            blink_cnt_d = blink_cnt_q + 8'd1;
                        end
                    end
                end
                default: begin
                    state_d     = ST_IDLE;
                    shown_d     = 4'd0;
                    frame_cnt_d = 8'd0;
                    blink_cnt_d = 8'd0;
                    blink_off_d = 1'b0;
                end
            endcase
        end

        reveal_done_d = (state_d == ST_HOLD);
    end

    // S1: text map with reveal/blink masking.
    always_comb begin
        visible = (cell_row == 4'd0) && (cell_col < TEXT_LEN_4) &&
                  (cell_col < shown_q) && !blink_off_q;
        code_d  = visible ? text_char(cell_col) : CH_BLANK;
    end

    font_rom_8x8 u_font_rom (
        .code       (code_q),
        .row        (char_line_game_over[5:3]),
        .row_bits_c (font_bits_c)
    );

    // S2: font row for the line presented this cycle, upscaled 8x.
    always_comb begin
        pix_d = expand_row(font_bits_c);
    end

    always_ff @(posedge pclk) begin
        vs_q <= vsync_in;
        if (rst) begin
            state_q       <= ST_IDLE;
            shown_q       <= 4'd0;
            frame_cnt_q   <= 8'd0;
            blink_cnt_q   <= 8'd0;
            blink_off_q   <= 1'b0;
            reveal_done_q <= 1'b0;
            code_q        <= 4'd0;
            pix_q         <= 64'd0;
        end else begin
            state_q       <= state_d;
            shown_q       <= shown_d;
            frame_cnt_q   <= frame_cnt_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_off_q   <= blink_off_d;
            reveal_done_q <= reveal_done_d;
            code_q        <= code_d;
            pix_q         <= pix_d;
        end
    end

    assign char_pixels_game_over = pix_q;
    assign reveal_done           = reveal_done_q;

endmodule

// File: tb/tb_game_over_glyph_fetch.sv
// Directed bench: two instances share stimulus, one without blink and one blinking every 2 frames.
module tb_game_over_glyph_fetch;

    logic        pclk = 1'b0;
    logic        rst;
    logic        game_over;
    logic        vsync_in;
    logic [7:0]  char_yx;
    logic [7:0]  char_line;
    logic [63:0] pix_a, pix_b;
    logic        done_a, done_b;

    int errors = 0;
    int checks = 0;

    logic [63:0] row0_tbl [9];

    always #5 pclk = ~pclk;

    game_over_glyph_fetch #(.REVEAL_FRAMES(2), .BLINK_FRAMES(0), .TEXT_LEN(9)) dut_a (
        .pclk                  (pclk),
        .rst                   (rst),
        .game_over             (game_over),
        .vsync_in              (vsync_in),
        .char_yx_game_over     (char_yx),
        .char_line_game_over   (char_line),
        .char_pixels_game_over (pix_a),
        .reveal_done           (done_a)
    );

    game_over_glyph_fetch #(.REVEAL_FRAMES(2), .BLINK_FRAMES(2), .TEXT_LEN(9)) dut_b (
        .pclk                  (pclk),
        .rst                   (rst),
        .game_over             (game_over),
        .vsync_in              (vsync_in),
        .char_yx_game_over     (char_yx),
        .char_line_game_over   (char_line),
        .char_pixels_game_over (pix_b),
        .reveal_done           (done_b)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic tick();
        vsync_in = 1'b1;
        step();
        vsync_in = 1'b0;
        step();
    endtask

    // yx first, line one clock later; pixels valid two clocks after yx.
    task automatic probe(input string tag, input logic [7:0] yx, input logic [7:0] line,
                         input logic [63:0] exp_a, input logic [63:0] exp_b);
        char_yx = yx;
        step();
        char_line = line;
        step();
        chk({tag, "_a"}, pix_a, exp_a);
        chk({tag, "_b"}, pix_b, exp_b);
    endtask

    initial begin
        row0_tbl[0] = 64'h0000_FFFF_FFFF_0000;  // G 3C
        row0_tbl[1] = 64'h0000_00FF_FF00_0000;  // A 18
        row0_tbl[2] = 64'hFFFF_0000_00FF_FF00;  // M C6
        row0_tbl[3] = 64'hFFFF_FFFF_FFFF_FF00;  // E FE
        row0_tbl[4] = 64'h0;                    // space
        row0_tbl[5] = 64'h00FF_FFFF_FFFF_0000;  // O 7C
        row0_tbl[6] = 64'hFFFF_0000_00FF_FF00;  // V C6
        row0_tbl[7] = 64'hFFFF_FFFF_FFFF_FF00;  // E FE
        row0_tbl[8] = 64'hFFFF_FFFF_FFFF_0000;  // R FC

        rst = 1'b1; game_over = 1'b1; vsync_in = 1'b0; char_yx = 8'h00; char_line = 8'h00;

        // Reset held with game_over high and vsync toggling
        for (int i = 0; i < 3; i++) begin
            vsync_in = ~vsync_in;
            step();
            chk("rst_pix", pix_a, 64'h0);
            chk("rst_done", {63'h0, done_a}, 64'h0);
        end
        vsync_in = 1'b0;
        rst = 1'b0;
        step();  // IDLE -> REVEAL, shown=1

        // Reveal pacing: shown advances every 2 ticks
        probe("shown1_col0", 8'h00, 8'h00, row0_tbl[0], row0_tbl[0]);
        probe("shown1_col1", 8'h01, 8'h00, 64'h0, 64'h0);
        for (int t = 1; t <= 16; t++) begin
            int exp_shown;
            tick();
            exp_shown = 1 + t / 2;
            chk($sformatf("done_t%0d", t), {63'h0, done_a}, {63'h0, t == 16});
            probe($sformatf("vis_t%0d", t), 8'(exp_shown - 1), 8'h00,
                  row0_tbl[exp_shown-1], row0_tbl[exp_shown-1]);
            if (exp_shown < 9)
                probe($sformatf("hid_t%0d", t), 8'(exp_shown), 8'h00, 64'h0, 64'h0);
        end
        chk("hold_done_b", {63'h0, done_b}, 64'h1);

        // Glyph data in HOLD
        char_line = 8'd63;
        probe("g_row0", 8'h00, 8'd0, 64'h0000_FFFF_FFFF_0000, 64'h0000_FFFF_FFFF_0000);
        probe("space", 8'h04, 8'd0, 64'h0, 64'h0);
        probe("g_hibits", 8'h00, 8'hC0, 64'h0000_FFFF_FFFF_0000, 64'h0000_FFFF_FFFF_0000);
        probe("a_row0", 8'h01, 8'd5, 64'h0000_00FF_FF00_0000, 64'h0000_00FF_FF00_0000);
        probe("e_row3", 8'h03, 8'd24, 64'hFFFF_FFFF_FFFF_0000, 64'hFFFF_FFFF_FFFF_0000);
        probe("e_row7", 8'h07, 8'd63, 64'h0, 64'h0);
        probe("v_row5", 8'h06, 8'd40, 64'h0000_FFFF_FF00_0000, 64'h0000_FFFF_FF00_0000);
        probe("r_row4", 8'h08, 8'd39, 64'hFFFF_00FF_FF00_0000, 64'hFFFF_00FF_FF00_0000);

        // Back-to-back addresses through the pipeline
        char_yx = 8'h00;
        step();
        char_line = 8'd0; char_yx = 8'h05;
        step();
        chk("pipe_g", pix_a, 64'h0000_FFFF_FFFF_0000);
        char_line = 8'd8;
        step();
        chk("pipe_o_row1", pix_a, 64'hFFFF_0000_00FF_FF00);

        // Out-of-range cells
        probe("col9", 8'h09, 8'd0, 64'h0, 64'h0);
        probe("col15", 8'h0F, 8'd0, 64'h0, 64'h0);
        probe("row1", 8'h10, 8'd0, 64'h0, 64'h0);

        // Leaving HOLD, then partial reveal at shown=3
        game_over = 1'b0;
        step();
        chk("drop_done_a", {63'h0, done_a}, 64'h0);
        chk("drop_done_b", {63'h0, done_b}, 64'h0);
        probe("idle_col0", 8'h00, 8'd0, 64'h0, 64'h0);
        game_over = 1'b1;
        step();
        for (int t = 0; t < 4; t++) tick();
        probe("part_col3", 8'h03, 8'd0, 64'h0, 64'h0);
        probe("part_m_row1", 8'h02, 8'd8, 64'hFFFF_FF00_FFFF_FF00, 64'hFFFF_FF00_FFFF_FF00);
        chk("part_done", {63'h0, done_a}, 64'h0);
        game_over = 1'b0;
        step();
        chk("part_drop_done", {63'h0, done_a}, 64'h0);
        probe("part_idle_col0", 8'h00, 8'd0, 64'h0, 64'h0);

        // Blink: dut_b toggles every 2 ticks, dut_a stays on
        game_over = 1'b1;
        step();
        for (int t = 0; t < 16; t++) tick();
        chk("blink_hold_a", {63'h0, done_a}, 64'h1);
        chk("blink_hold_b", {63'h0, done_b}, 64'h1);
        for (int k = 1; k <= 6; k++) begin
            logic on;
            tick();
            on = ((k / 2) % 2) == 0;
            probe($sformatf("blink_k%0d", k), 8'h00, 8'd0, row0_tbl[0], on ? row0_tbl[0] : 64'h0);
        end

        // Tick coinciding with game_over falling, then another tick in IDLE
        game_over = 1'b0; vsync_in = 1'b1;
        step();
        chk("fall_done_a", {63'h0, done_a}, 64'h0);
        chk("fall_done_b", {63'h0, done_b}, 64'h0);
        vsync_in = 1'b0;
        step();
        tick();
        probe("fall_idle", 8'h00, 8'd0, 64'h0, 64'h0);
        game_over = 1'b1;
        step();
        probe("restart_col0", 8'h00, 8'd0, row0_tbl[0], row0_tbl[0]);

        // Reset mid-reveal clears outputs the next cycle
        char_yx = 8'h00; char_line = 8'd0;
        step();
        rst = 1'b1;
        step();
        chk("midrst_pix", pix_a, 64'h0);
        chk("midrst_done", {63'h0, done_a}, 64'h0);
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
